// File: rtl/mm_cmd_loader.sv
// mm_cmd_loader
// Command-side receive stage of the matrix-multiply accelerator. It parses a
// MATRIX_MULT packet (command byte, dimension bytes a_h, a_w, h_h, h_w, then
// the A and H operands as big-endian 32-bit floats). Each operand is written
// row-major into the A/H operand buffers, one word per write, and the block
// pulses load_done when both operands are in.
//
// Optional feature: define MM_CMD_DIM_CHECK_EN to reject packets that have a
// zero dimension, a dimension above MAX_DIM, or a_w != h_h (cmd_err pulse).
// Without the macro cmd_err is constant 0, a zero count skips that operand,
// and oversize operands wrap the buffer address.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_valid, rx_data one-cycle byte strobe and byte from the UART receiver
//   wr_en             one-cycle operand write strobe
//   wr_sel            0 = A buffer, 1 = H buffer
//   wr_addr, wr_data  row-major word address, assembled float (first byte MSB)
//   a_h,a_w,h_h,h_w   latched dimensions
//   busy              high whenever the FSM is not in IDLE
//   load_done         one-cycle pulse after the final operand write
//   cmd_err           one-cycle pulse on a rejected packet
//   state_dbg         current FSM state, for checkers
//
// Handshake: rx_valid is a one-cycle qualifier with no ready; a byte is
// consumed on every clock edge where rx_valid is high. wr_en is a one-cycle
// qualifier, and the buffers must accept every write.
module mm_cmd_loader #(
  parameter logic [7:0] CMD_MATMUL = 8'h02,
  parameter int         MAX_DIM    = 16,
  parameter int         ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [7:0]        a_h,
  output logic [7:0]        a_w,
  output logic [7:0]        h_h,
  output logic [7:0]        h_w,
  output logic              busy,
  output logic              load_done,
  output logic              cmd_err,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIMS   = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_H = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

  state_t      state_q, state_d;
  logic [1:0]  dim_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;     // bytes already received for the current word
  logic [15:0] elem_idx;
  logic [15:0] n_a, n_h;

  logic [15:0] n_a_new, n_h_new;
  logic        dim_done;  // fourth dimension byte arriving this cycle
  logic        dim_bad;
  logic        word_done; // fourth byte of an operand word arriving this cycle
  logic        elem_last;

  always_comb begin
    state_d   = state_q;
    dim_done  = 1'b0;
    dim_bad   = 1'b0;
    word_done = 1'b0;
    elem_last = 1'b0;
    // h_w is still on rx_data when the counts are formed.
    n_a_new   = {8'd0, a_h} * {8'd0, a_w};
    n_h_new   = {8'd0, h_h} * {8'd0, rx_data};
`ifdef MM_CMD_DIM_CHECK_EN
    dim_bad = (a_h == 8'd0) || (a_w == 8'd0) || (h_h == 8'd0) ||
              (rx_data == 8'd0) || (a_h > MAX_DIM_B) || (a_w > MAX_DIM_B) ||
              (h_h > MAX_DIM_B) || (rx_data > MAX_DIM_B) || (a_w != h_h);
`endif
    elem_last = (state_q == S_LOAD_H) ? (elem_idx == n_h - 16'd1)
                                      : (elem_idx == n_a - 16'd1);
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == CMD_MATMUL) state_d = S_DIMS;
      end
      S_DIMS: begin
        if (rx_valid && dim_idx == 2'd3) begin
          dim_done = 1'b1;
          if (dim_bad)                  state_d = S_IDLE;
          else if (n_a_new != 16'd0)    state_d = S_LOAD_A;
          else if (n_h_new != 16'd0)    state_d = S_LOAD_H;
          else                          state_d = S_DONE;
        end
      end
      S_LOAD_A: begin
        if (rx_valid && byte_cnt == 2'd3) begin
          word_done = 1'b1;
          if (elem_last) state_d = (n_h != 16'd0) ? S_LOAD_H : S_DONE;
        end
      end
      S_LOAD_H: begin
        if (rx_valid && byte_cnt == 2'd3) begin
          word_done = 1'b1;
          if (elem_last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;   // any byte arriving here is dropped
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_idx   <= 2'd0;
      byte_cnt  <= 2'd0;
      asm_q     <= 24'd0;
      elem_idx  <= 16'd0;
      n_a       <= 16'd0;
      n_h       <= 16'd0;
      a_h       <= 8'd0;
      a_w       <= 8'd0;
      h_h       <= 8'd0;
      h_w       <= 8'd0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 32'd0;
      load_done <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= (state_q == S_DONE);
      cmd_err   <= dim_done && dim_bad;

      if (state_q == S_IDLE && rx_valid && rx_data == CMD_MATMUL) begin
        dim_idx  <= 2'd0;
        byte_cnt <= 2'd0;
        elem_idx <= 16'd0;
      end

      if (state_q == S_DIMS && rx_valid) begin
        case (dim_idx)
          2'd0:    a_h <= rx_data;
          2'd1:    a_w <= rx_data;
          2'd2:    h_h <= rx_data;
          default: h_w <= rx_data;
        endcase
        dim_idx <= dim_idx + 2'd1;
      end

      if (dim_done) begin
        n_a      <= n_a_new;
        n_h      <= n_h_new;
        elem_idx <= 16'd0;
        byte_cnt <= 2'd0;
      end

      if ((state_q == S_LOAD_A || state_q == S_LOAD_H) && rx_valid) begin
        byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 after the fourth byte
        asm_q    <= {asm_q[15:0], rx_data};
      end

      if (word_done) begin
        wr_en    <= 1'b1;
        wr_sel   <= (state_q == S_LOAD_H);
        wr_addr  <= elem_idx[ADDR_W-1:0];  // oversize operands wrap here
        wr_data  <= {asm_q, rx_data};
        // Index restarts at 0 when A completes so H begins at address 0.
        elem_idx <= elem_last ? 16'd0 : elem_idx + 16'd1;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mm_cmd_loader.sv
// Bench for mm_cmd_loader: drives MATRIX_MULT packets byte by byte and
// checks each operand write against an expected queue of {sel, addr, data}.
module tb_mm_cmd_loader;

  localparam int ADDR_W = 8;
  localparam int EXP_W  = 1 + ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wr_en, wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [7:0]        a_h, a_w, h_h, h_w;
  logic              busy, load_done, cmd_err;
  logic [2:0]        state_dbg;

  mm_cmd_loader #(.CMD_MATMUL(8'h02), .MAX_DIM(16), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .a_h(a_h), .a_w(a_w), .h_h(h_h), .h_w(h_w),
    .busy(busy), .load_done(load_done), .cmd_err(cmd_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  int cyc = 0, wr_cnt = 0, ld_cnt = 0, err_cnt = 0, busy_cyc = 0;
  int last_wr_cyc = 0;
  logic pkt_has_writes = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (busy) busy_cyc++;
      if (cmd_err) err_cnt++;
      if (wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) check("wr_unexpected", 64'(wr_addr), 64'hdead);
        else check("wr_word", 64'({wr_sel, wr_addr, wr_data}), 64'(exp_q.pop_front()));
      end
      if (load_done) begin
        ld_cnt++;
        if (pkt_has_writes) check("ld_after_wr", 64'(cyc - last_wr_cyc), 64'd1);
      end
    end
  end

  function automatic logic [31:0] fbits(input int v);
    case (v)
      1: return 32'h3F800000;  2: return 32'h40000000;
      3: return 32'h40400000;  4: return 32'h40800000;
      5: return 32'h40A00000;  6: return 32'h40C00000;
      7: return 32'h40E00000;  8: return 32'h41000000;
      9: return 32'h41100000;  10: return 32'h41200000;
      11: return 32'h41300000; 12: return 32'h41400000;
      13: return 32'h41500000; 14: return 32'h41600000;
      15: return 32'h41700000; default: return 32'h41800000;
    endcase
  endfunction

  function automatic logic dims_bad(input int ah, input int aw, input int hh,
                                    input int hw);
`ifdef MM_CMD_DIM_CHECK_EN
    return (ah == 0 || aw == 0 || hh == 0 || hw == 0 || ah > 16 || aw > 16 ||
            hh > 16 || hw > 16 || aw != hh);
`else
    return 1'b0;
`endif
  endfunction

  // driver: called just after a rising edge, returns just after a rising edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 3; k >= 0; k--)
      send_byte(w[8*k +: 8], $urandom_range(0, gap_max));
  endtask

  task automatic send_pkt(input int ah, input int aw, input int hh,
                          input int hw, input bit ramp, input int gap_max);
    int w0, l0, e0, na, nh;
    logic bad;
    logic [31:0] d;
    w0 = wr_cnt; l0 = ld_cnt; e0 = err_cnt;
    na = ah * aw; nh = hh * hw;
    bad = dims_bad(ah, aw, hh, hw);
    pkt_has_writes = !bad && (na + nh > 0);
    send_byte(8'h02, $urandom_range(0, gap_max));
    send_byte(8'(ah), $urandom_range(0, gap_max));
    send_byte(8'(aw), $urandom_range(0, gap_max));
    send_byte(8'(hh), $urandom_range(0, gap_max));
    send_byte(8'(hw), 0);
    if (bad) begin
      @(negedge clk);
      check("cmd_err_pulse", 64'(cmd_err), 64'd1);
      check("busy_after_err", 64'(busy), 64'd0);
      @(negedge clk);
      check("cmd_err_one_cycle", 64'(cmd_err), 64'd0);
    end else if (na + nh == 0) begin
      @(negedge clk);
      check("zero_ld_early", 64'(load_done), 64'd0);
      @(negedge clk);
      check("zero_ld_pulse", 64'(load_done), 64'd1);
    end else begin
      for (int s = 0; s < 2; s++) begin
        for (int e = 0; e < (s == 0 ? na : nh); e++) begin
          d = ramp ? fbits(e + 1) : $urandom;
          exp_q.push_back({s[0], 8'(e), d});
          send_word(d, gap_max);
        end
      end
      for (int t = 0; t < 40 && ld_cnt == l0; t++) @(posedge clk);
    end
    repeat (3) @(posedge clk); #1;
    check("pkt_writes", 64'(wr_cnt - w0), bad ? 64'd0 : 64'(na + nh));
    check("pkt_load_done", 64'(ld_cnt - l0), bad ? 64'd0 : 64'd1);
    check("pkt_cmd_err", 64'(err_cnt - e0), bad ? 64'd1 : 64'd0);
    check("pkt_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int b0, w0, l0;
    logic [31:0] d;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_cmd_err", 64'(cmd_err), 64'd0);
    check("rst_wr_bus", 64'({wr_sel, wr_addr, wr_data}), 64'd0);
    check("rst_dims", 64'({a_h, a_w, h_h, h_w}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // non-command bytes in IDLE are ignored
    b0 = busy_cyc; w0 = wr_cnt; l0 = ld_cnt;
    send_byte(8'h55, 1);
    send_byte(8'hAA, 2);
    repeat (2) @(posedge clk); #1;
    check("idle_busy", 64'(busy_cyc - b0), 64'd0);
    check("idle_writes", 64'(wr_cnt - w0), 64'd0);
    check("idle_pulses", 64'(ld_cnt - l0), 64'd0);

    // 4x4 with float ramp, back-to-back bytes
    send_pkt(4, 4, 4, 4, 1'b1, 0);
    check("dims_latched", 64'({a_h, a_w, h_h, h_w}), 64'h04040404);
    send_pkt(2, 3, 3, 1, 1'b0, 3);

    // reset partway through A element 5
    pkt_has_writes = 1'b1;
    send_byte(8'h02, 0);
    for (int k = 0; k < 4; k++) send_byte(8'd4, 1);
    for (int e = 0; e < 5; e++) begin
      d = $urandom;
      exp_q.push_back({1'b0, 8'(e), d});
      send_word(d, 1);
    end
    send_byte(8'h3F, 0);
    send_byte(8'h80, 1);
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_wr_bus", 64'({wr_en, wr_sel, wr_addr, wr_data}), 64'd0);
    check("mid_rst_dims", 64'({a_h, a_w, h_h, h_w}), 64'd0);
    check("mid_rst_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(4, 4, 4, 4, 1'b0, 2);

    // dimension-check cases, zero counts
    send_pkt(2, 3, 2, 2, 1'b0, 1);
    send_pkt(17, 1, 1, 1, 1'b0, 0);
    send_pkt(0, 5, 0, 3, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mm_cmd_loader.md
# mm_cmd_loader

Command-side receive stage for the matrix-multiply accelerator. Sits directly downstream of the UART receiver (after its one-cycle rx_done edge detector) and upstream of the A/H operand buffers. Parses a MATRIX_MULT packet (command byte, four dimension bytes, then A and H operands as big-endian IEEE-754 single-precision words) and issues row-major word writes into the operand buffers, then signals load completion.

## Interface
Parameters:
- CMD_MATMUL, 8'h02, command byte value that starts a load
- MAX_DIM, 16, largest legal row/column count
- ADDR_W, 8, operand buffer word-address width (must hold MAX_DIM*MAX_DIM-1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- wr_en  out  1  one-cycle operand write strobe
- wr_sel  out  1  0 = A buffer, 1 = H buffer
- wr_addr  out  ADDR_W  row-major word address (row*width+col)
- wr_data  out  32  assembled float, first byte in [31:24]
- a_h, a_w, h_h, h_w  out  8 each  latched dimensions
- busy  out  1  high in any state other than IDLE
- load_done  out  1  one-cycle pulse, both operands written
- cmd_err  out  1  one-cycle pulse, packet rejected (DIM_CHECK_EN only)

Clock is clk; reset is rst_n, asynchronous, active-low.

## Operation
- States: IDLE, DIMS, LOAD_A, LOAD_H, DONE.
- IDLE: rx_valid with rx_data == CMD_MATMUL -> DIMS; any other byte ignored, no pulse.
- DIMS: four bytes latched in order a_h, a_w, h_h, h_w. On the fourth: counts n_a = a_h*a_w, n_h = h_h*h_w computed at 16 bits. Next state LOAD_A if n_a != 0, else LOAD_H if n_h != 0, else DONE.
- LOAD_A/LOAD_H: 2-bit byte counter shifts bytes MSB-first into a 32-bit assembler; on fourth byte wr_en pulses with wr_addr = element index[ADDR_W-1:0]; element index increments. After element n_a-1 -> LOAD_H (index cleared) or DONE; after element n_h-1 -> DONE.
- DONE: load_done for one cycle, -> IDLE. Dimension outputs hold until the next accepted dimension byte.
- Bytes arriving in DONE are dropped (upstream UART spacing makes this unreachable in normal use).
- Element index exceeding 2^ADDR_W wraps the address (truncation); no other protection without DIM_CHECK_EN.

## Timing
- Reset: state IDLE; wr_en, busy, load_done, cmd_err = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; all dimension outputs = 0; counters 0.
- Accepts rx_valid every cycle; no backpressure, buffers accept writes unconditionally.
- wr_en/wr_addr/wr_data/wr_sel registered: valid the cycle after the rx_valid carrying the 4th byte of a word; held stable until next write (wr_en only one cycle).
- load_done: cycle after the final wr_en (or two cycles after the 4th dim byte when both counts are 0).
- busy rises the cycle after the command byte, falls with load_done/cmd_err cycle+1.
- rst_n asserted mid-packet: immediate return to IDLE, partial word discarded, no pulses.

## Configuration
- MM_CMD_DIM_CHECK_EN defined: after the fourth dimension byte, reject if any dimension is 0, any dimension > MAX_DIM, or a_w != h_h. Rejection: cmd_err one-cycle pulse the next cycle, -> IDLE, no writes; following operand bytes are parsed as IDLE traffic (ignored unless equal to CMD_MATMUL).
- Not defined: no checks, cmd_err tied 0; zero counts skip that operand, oversize wraps addresses.

## Test plan
- Cmd, dims 4,4,4,4, floats 1.0..16.0 twice -> 32 wr_en; first A write addr 0 data 32'h3F800000; last H write sel 1, addr 15, data 32'h41800000; one load_done.
- Bytes 8'h55 then 8'hAA in IDLE -> busy stays 0, no wr_en, no pulses.
- Dims 2,3,3,1 -> 6 A writes addr 0..5, 3 H writes addr 0..2, load_done one cycle after last write.
- rst_n low after 2 bytes of A element 5 -> outputs at reset values; fresh 4x4 packet then loads from addr 0 correctly.
- MM_CMD_DIM_CHECK_EN defined, dims 2,3,2,2 -> cmd_err pulse, zero writes; dims 17,1,1,1 -> cmd_err; without macro dims 2,3,2,2 -> 6+4 writes, load_done.
- rx_valid on consecutive cycles for a whole packet -> every word written, no byte lost.
